// File: rtl/cordic_pkg.sv
// Shared constants and types for the CORDIC rotation pipeline.
// The front-end prerotator and the micro-rotation stage chain both import this.
package cordic_pkg;
  localparam int PHASE_W = 32;
  localparam int DATA_W  = 9;
  localparam logic [PHASE_W-1:0] PHASE_90 = 32'h4000_0000;

  // atan(2^-i) in 2^32 counts per full circle, for the micro-rotation stages
  localparam int ATAN_N = 8;
  localparam logic [PHASE_W-1:0] ATAN_TAB [0:ATAN_N-1] = '{
    32'h2000_0000, 32'h12E4_051E, 32'h09FB_385B, 32'h0511_11D4,
    32'h028B_0D43, 32'h0145_D7E1, 32'h00A2_F61E, 32'h0051_7C55
  };

  localparam logic signed [DATA_W-1:0] DATA_MIN = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic signed [DATA_W-1:0] DATA_MAX = {1'b0, {(DATA_W-1){1'b1}}};

  typedef struct packed {
    logic signed [DATA_W-1:0] x;
    logic signed [DATA_W-1:0] y;
    logic [PHASE_W-1:0]       p;
    logic                     sat;
  } sample_t;

  localparam int SAMPLE_W = $bits(sample_t);

  typedef enum logic [1:0] {BUF_EMPTY, BUF_ONE, BUF_FULL} buf_state_t;

  // Two's complement negation that clamps the one unrepresentable case
  function automatic logic signed [DATA_W-1:0] neg_sat(input logic signed [DATA_W-1:0] v);
    return (v == DATA_MIN) ? DATA_MAX : -v;
  endfunction
endpackage

// File: rtl/cordic_quadrant_prerotator_if.sv
// Sample-in / sample-out bus of the quadrant prerotator, plus saturation status.
interface cordic_quadrant_prerotator_if #(parameter int SAT_CNT_W = 16);
  import cordic_pkg::*;

  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] x_in;
  logic signed [DATA_W-1:0] y_in;
  logic [PHASE_W-1:0]       phase_in;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [DATA_W-1:0] x_out;
  logic signed [DATA_W-1:0] y_out;
  logic [PHASE_W-1:0]       p_out;
  logic                     sat_flag;
  logic [SAT_CNT_W-1:0]     sat_count;
  logic                     sat_clr;

  modport master (
    output in_valid, x_in, y_in, phase_in, out_ready, sat_clr,
    input  in_ready, out_valid, x_out, y_out, p_out, sat_flag, sat_count
  );

  modport slave (
    input  in_valid, x_in, y_in, phase_in, out_ready, sat_clr,
    output in_ready, out_valid, x_out, y_out, p_out, sat_flag, sat_count
  );
endinterface

// File: rtl/cordic_skid_buffer.sv
// Generic 2-entry valid/ready buffer: output register plus one skid register.
// in_ready is registered, so a sample arriving as the sink stalls lands in the skid slot.
module cordic_skid_buffer
  import cordic_pkg::*;
#(
  parameter int W = SAMPLE_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] din,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] dout
);
  buf_state_t   state, state_nx;
  logic [W-1:0] out_q, skid_q;
  logic         in_ready_q;
  logic         in_xfer, out_xfer;
  logic         ld_out, ld_skid, skid_to_out;

  assign in_ready  = in_ready_q;
  assign out_valid = (state != BUF_EMPTY);
  assign dout      = out_q;
  assign in_xfer   = in_valid && in_ready_q;
  assign out_xfer  = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= BUF_EMPTY;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx    = state;
    ld_out      = 1'b0;
    ld_skid     = 1'b0;
    skid_to_out = 1'b0;
    case (state)
      BUF_EMPTY: if (in_xfer) begin
        state_nx = BUF_ONE;
        ld_out   = 1'b1;
      end
      BUF_ONE: begin
        if (in_xfer && out_xfer) ld_out = 1'b1;
        else if (in_xfer) begin
          state_nx = BUF_FULL;
          ld_skid  = 1'b1;
        end else if (out_xfer) state_nx = BUF_EMPTY;
      end
      BUF_FULL: if (out_xfer) begin
        state_nx    = BUF_ONE;
        skid_to_out = 1'b1;
      end
      default: state_nx = BUF_EMPTY;
    endcase
  end

  // in_ready looks at next state so it is already low in the cycle the buffer is full
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_q      <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b0;
    end else begin
      in_ready_q <= (state_nx != BUF_FULL);
      if (ld_out)           out_q <= din;
      else if (skid_to_out) out_q <= skid_q;
      if (ld_skid)          skid_q <= din;
    end
  end
endmodule

// File: rtl/cordic_quadrant_prerotator.sv
// CORDIC front end: folds a full-circle phase into [-90, +90) by an exact +/-90 degree
// rotation of (x, y), then hands the sample to stage 0 through a skid buffer.
module cordic_quadrant_prerotator
  import cordic_pkg::*;
#(
  parameter int LOG2_PHASE_SCALE = 1,
  parameter int SAT_CNT_W        = 16
) (
  input logic clk,
  input logic rst_n,
  cordic_quadrant_prerotator_if.slave bus
);
  sample_t              fold, held;
  logic [PHASE_W-1:0]   ph;
  logic [SAT_CNT_W-1:0] sat_cnt_q;
  logic                 in_xfer;

  always_comb begin
    fold.x   = bus.x_in;
    fold.y   = bus.y_in;
    fold.sat = 1'b0;
    ph       = bus.phase_in;
    case (bus.phase_in[PHASE_W-1 -: 2])
      2'b01: begin
        fold.x   = neg_sat(bus.y_in);
        fold.y   = bus.x_in;
        fold.sat = (bus.y_in == DATA_MIN);
        ph       = bus.phase_in - PHASE_90;
      end
      2'b10: begin
        fold.x   = bus.y_in;
        fold.y   = neg_sat(bus.x_in);
        fold.sat = (bus.x_in == DATA_MIN);
        ph       = bus.phase_in + PHASE_90;
      end
      default: ;
    endcase
    fold.p = $signed(ph) >>> LOG2_PHASE_SCALE;
  end

  cordic_skid_buffer #(.W(SAMPLE_W)) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (bus.in_valid),
    .in_ready  (bus.in_ready),
    .din       (fold),
    .out_valid (bus.out_valid),
    .out_ready (bus.out_ready),
    .dout      (held)
  );

  assign in_xfer = bus.in_valid && bus.in_ready;

  // Counted at acceptance so a stalled sample is never counted twice; clear has priority
  always_ff @(posedge clk) begin
    if (!rst_n)                                       sat_cnt_q <= '0;
    else if (bus.sat_clr)                             sat_cnt_q <= '0;
    else if (in_xfer && fold.sat && sat_cnt_q != '1)  sat_cnt_q <= sat_cnt_q + 1'b1;
  end

  assign bus.x_out     = held.x;
  assign bus.y_out     = held.y;
  assign bus.p_out     = held.p;
  assign bus.sat_flag  = held.sat;
  assign bus.sat_count = sat_cnt_q;
endmodule

// File: tb/tb_cordic_quadrant_prerotator.sv
// Directed bench for the quadrant prerotator: fold cases, saturation, stall and reset flush.
module tb_cordic_quadrant_prerotator;
  logic clk = 1'b0;
  logic rst_n;
  int   n_chk  = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  cordic_quadrant_prerotator_if #(.SAT_CNT_W(16)) bus ();

  cordic_quadrant_prerotator #(.LOG2_PHASE_SCALE(0), .SAT_CNT_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  // One-cycle input pulse; outputs are sampled at the negedge after acceptance
  task automatic send(input logic signed [8:0] x, input logic signed [8:0] y,
                      input logic [31:0] ph, input logic clr);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.x_in     = x;
    bus.y_in     = y;
    bus.phase_in = ph;
    bus.sat_clr  = clr;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.sat_clr  = 1'b0;
  endtask

  int sent, recv;
  logic in_x, out_x;

  initial begin
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.x_in     = '0;
    bus.y_in     = '0;
    bus.phase_in = '0;
    bus.out_ready = 1'b1;
    bus.sat_clr  = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_x_out", bus.x_out, 0);
    chk("rst_sat_count", bus.sat_count, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", bus.in_ready, 1);

    send(100, 50, 32'h2000_0000, 0);
    chk("q0_valid", bus.out_valid, 1);
    chk("q0_x", bus.x_out, 100);
    chk("q0_y", bus.y_out, 50);
    chk("q0_p", bus.p_out, 32'h2000_0000);

    send(100, 50, 32'h6000_0000, 0);
    chk("q1_x", bus.x_out, -50);
    chk("q1_y", bus.y_out, 100);
    chk("q1_p", bus.p_out, 32'h2000_0000);

    send(100, 50, 32'hA000_0000, 0);
    chk("q2_x", bus.x_out, 50);
    chk("q2_y", bus.y_out, -100);
    chk("q2_p", bus.p_out, 32'hE000_0000);
    chk("q2_sat_flag", bus.sat_flag, 0);

    send(-256, 7, 32'h8000_0000, 0);
    chk("sat_x", bus.x_out, 7);
    chk("sat_y", bus.y_out, 255);
    chk("sat_p", bus.p_out, 32'hC000_0000);
    chk("sat_flag", bus.sat_flag, 1);
    chk("sat_count1", bus.sat_count, 1);

    send(-256, 7, 32'h8000_0000, 1);
    chk("clr_wins_count", bus.sat_count, 0);
    chk("clr_sat_flag", bus.sat_flag, 1);

    send(3, -256, 32'h4000_0000, 0);
    chk("q1_edge_x", bus.x_out, 255);
    chk("q1_edge_y", bus.y_out, 3);
    chk("q1_edge_p", bus.p_out, 32'h0000_0000);
    chk("q1_edge_count", bus.sat_count, 1);

    send(-5, 9, 32'h3FFF_FFFF, 0);
    chk("q0_edge_x", bus.x_out, -5);
    chk("q0_edge_p", bus.p_out, 32'h3FFF_FFFF);
    chk("q0_edge_sat", bus.sat_flag, 0);

    @(negedge clk);
    chk("drained", bus.out_valid, 0);

    // Stream 10 samples with a 3-cycle sink stall
    sent = 0;
    recv = 0;
    for (int cyc = 0; cyc < 40 && recv < 10; cyc++) begin
      if (cyc > 0) @(negedge clk);
      bus.out_ready = !(cyc >= 3 && cyc <= 5);
      bus.in_valid  = (sent < 10);
      bus.x_in      = 9'(10 + sent);
      bus.y_in      = 9'(20 + sent);
      bus.phase_in  = 32'(sent) << 8;
      if (cyc == 4) chk("full_in_ready", bus.in_ready, 0);
      if (cyc == 5) begin
        chk("stall_valid", bus.out_valid, 1);
        chk("stall_hold_x", bus.x_out, 12);
      end
      #1;
      in_x  = bus.in_valid && bus.in_ready;
      out_x = bus.out_valid && bus.out_ready;
      if (out_x) begin
        chk("strm_x", bus.x_out, 64'(10 + recv));
        chk("strm_p", bus.p_out, 64'(recv << 8));
        recv++;
      end
      if (in_x) sent++;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("strm_recv", recv, 10);
    chk("strm_sent", sent, 10);
    @(negedge clk);
    chk("strm_no_dup", bus.out_valid, 0);

    // Reset with two samples buffered
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.x_in      = -256;
    bus.y_in      = 1;
    bus.phase_in  = 32'h8000_0000;
    @(negedge clk);
    bus.x_in      = 1;
    bus.y_in      = 2;
    bus.phase_in  = 32'h0;
    @(negedge clk);
    bus.in_valid  = 1'b0;
    chk("pre_rst_full", bus.in_ready, 0);
    chk("pre_rst_count", bus.sat_count, 2);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", bus.out_valid, 0);
    chk("mid_rst_count", bus.sat_count, 0);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("no_stale", bus.out_valid, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
